axi_addr_decoder_n: RTL and testbench



---
 rtl/axi_dec_pkg.sv | 14 +
 rtl/axi_dec_out_slice.sv | 38 +++
 rtl/axi_addr_decoder_n.sv | 73 +++++++
 tb/tb_axi_addr_decoder_n.sv | 139 +++++++++++++
 4 files changed

// File: rtl/axi_dec_pkg.sv
// axi_dec_pkg: shared decode constants, slave index type and default address decode
package axi_dec_pkg;
    localparam int NUM_SLV = 2;
    localparam int DEC_MSB = 31;
    localparam int DEC_LSB = 16;
    localparam logic [DEC_MSB-DEC_LSB:0] SLAVE0 = 16'h0000;
    localparam logic [DEC_MSB-DEC_LSB:0] SLAVE1 = 16'h0001;
    typedef logic [$clog2(NUM_SLV+1)-1:0] sel_t;
    localparam sel_t DEFAULT_IDX = sel_t'(NUM_SLV);
    function automatic sel_t decode(input logic [31:0] addr);
        return addr[DEC_MSB:DEC_LSB] == SLAVE0 ? sel_t'(0) :
               addr[DEC_MSB:DEC_LSB] == SLAVE1 ? sel_t'(1) : DEFAULT_IDX;
    endfunction
endpackage

// File: rtl/axi_dec_out_slice.sv
// axi_dec_out_slice: one-entry register slice holding address and slave index ahead of the m_* outputs
module axi_dec_out_slice #(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 2,
    parameter int SEL_W   = $clog2(NUM_SLV+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [SEL_W-1:0]   in_idx,
    output logic               in_ready,
    output logic [ADDR_W-1:0]  m_addr,
    output logic [NUM_SLV:0]   m_valid,
    input  logic [NUM_SLV:0]   m_ready
);
    localparam int NV = NUM_SLV + 1;
    logic              full;
    logic [SEL_W-1:0]  idx_q;
    logic              drain;
    assign drain    = full & m_ready[idx_q];
    assign in_ready = !full | drain;
    assign m_valid  = NV'(full) << idx_q;
    // slot fills on an accepted request and empties when its slave takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 1'b0;
            idx_q  <= SEL_W'(NUM_SLV);
            m_addr <= '0;
        end else begin
            full <= load | (full & !drain);
            if (load) begin
                idx_q  <= in_idx;
                m_addr <= in_addr;
            end
        end
    end
endmodule

// File: rtl/axi_addr_decoder_n.sv
// axi_addr_decoder_n: N-slave address decoder with outstanding-count route lock; AXI_DEC_OUT_REG_EN adds an output slice
module axi_addr_decoder_n
    import axi_dec_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = axi_dec_pkg::NUM_SLV,
    parameter int DEC_MSB = axi_dec_pkg::DEC_MSB,
    parameter int DEC_LSB = axi_dec_pkg::DEC_LSB,
    parameter logic [DEC_MSB-DEC_LSB:0] SLV_BASE [NUM_SLV] = '{SLAVE0, SLAVE1},
    parameter int MAX_OUTST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             s_addr,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [ADDR_W-1:0]             m_addr,
    output logic [NUM_SLV:0]              m_valid,
    input  logic [NUM_SLV:0]              m_ready,
    input  logic                          resp_done,
    output logic [$clog2(NUM_SLV+1)-1:0]  cur_sel,
    output logic                          busy,
    output logic                          underflow_err
);
    localparam int SEL_W = $clog2(NUM_SLV+1);
    localparam int CNT_W = $clog2(MAX_OUTST+1);
    logic [SEL_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             allow;
    logic             accept;
    logic             dec;
    // lowest matching slave wins; no match routes to the default slave
    always_comb begin
        idx = SEL_W'(NUM_SLV);
        for (int i = NUM_SLV-1; i >= 0; i--)
            if (s_addr[DEC_MSB:DEC_LSB] == SLV_BASE[i]) idx = SEL_W'(i);
    end
    assign allow  = (cnt == '0) | ((idx == cur_sel) & (cnt < CNT_W'(MAX_OUTST)));
    assign accept = s_valid & s_ready;
    assign dec    = resp_done & ((cnt != '0) | accept);
    assign busy   = cnt != '0;
`ifdef AXI_DEC_OUT_REG_EN
    logic slot_ready;
    assign s_ready = !rst & allow & slot_ready;
    axi_dec_out_slice #(.ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV), .SEL_W(SEL_W)) u_slice (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .in_addr  (s_addr),
        .in_idx   (idx),
        .in_ready (slot_ready),
        .m_addr   (m_addr),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );
`else
    assign s_ready = !rst & allow & m_ready[idx];
    assign m_valid = (NUM_SLV+1)'(s_valid & allow & !rst) << idx;
    assign m_addr  = s_addr;
`endif
    // outstanding count, route lock taken on the first accept, sticky underflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            cur_sel       <= SEL_W'(NUM_SLV);
            underflow_err <= 1'b0;
        end else begin
            cnt <= cnt + CNT_W'(accept) - CNT_W'(dec);
            if (accept && cnt == '0) cur_sel <= idx;
            if (resp_done && cnt == '0 && !accept) underflow_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_addr_decoder_n.sv
// tb_axi_addr_decoder_n: directed self-checking bench for the pass-through decoder build
module tb_axi_addr_decoder_n;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_addr = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] m_addr;
    logic [2:0]  m_valid;
    logic [2:0]  m_ready = '0;
    logic        resp_done = 1'b0;
    logic [1:0]  cur_sel;
    logic        busy;
    logic        underflow_err;
    int          n_chk = 0;
    int          n_ok  = 0;

    axi_addr_decoder_n dut (
        .clk           (clk),
        .rst           (rst),
        .s_addr        (s_addr),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_addr        (m_addr),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .resp_done     (resp_done),
        .cur_sel       (cur_sel),
        .busy          (busy),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_ok++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [2:0] r, input logic d);
        s_valid = v; s_addr = a; m_ready = r; resp_done = d;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick;
        drive(1, 32'h0001_0040, 3'b111, 0);
        chk("rst_sready", 32'(s_ready), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        tick;
        rst = 1'b0;
        drive(0, 32'h0001_0040, 3'b010, 0);
        chk("idle_mvalid", 32'(m_valid), 32'd0);
        chk("idle_cursel", 32'(cur_sel), 32'd2);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_sready", 32'(s_ready), 32'd1);
        chk("idle_uf", 32'(underflow_err), 32'd0);
        drive(1, 32'h0001_0040, 3'b010, 0);
        chk("s1_mvalid", 32'(m_valid), 32'b010);
        chk("s1_sready", 32'(s_ready), 32'd1);
        chk("s1_maddr", m_addr, 32'h0001_0040);
        tick;
        chk("s1_busy", 32'(busy), 32'd1);
        chk("s1_cursel", 32'(cur_sel), 32'd1);
        drive(1, 32'h0001_0044, 3'b010, 0);
        chk("s1b_sready", 32'(s_ready), 32'd1);
        tick;
        drive(1, 32'h0000_1000, 3'b111, 1);
        chk("lock_mvalid0", 32'(m_valid), 32'd0);
        chk("lock_sready0", 32'(s_ready), 32'd0);
        tick;
        drive(1, 32'h0000_1000, 3'b111, 1);
        chk("lock_mvalid1", 32'(m_valid), 32'd0);
        chk("lock_sready1", 32'(s_ready), 32'd0);
        tick;
        drive(1, 32'h0000_1000, 3'b111, 0);
        chk("relock_mvalid", 32'(m_valid), 32'b001);
        chk("relock_sready", 32'(s_ready), 32'd1);
        tick;
        chk("relock_cursel", 32'(cur_sel), 32'd0);
        chk("relock_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0000_2000, 3'b001, 0);
            chk("b2b_sready", 32'(s_ready), 32'd1);
            tick;
        end
        drive(1, 32'h0000_2000, 3'b001, 1);
        chk("full_sready", 32'(s_ready), 32'd0);
        chk("full_mvalid", 32'(m_valid), 32'd0);
        tick;
        drive(1, 32'h0000_2000, 3'b001, 0);
        chk("refill_sready", 32'(s_ready), 32'd1);
        tick;
        drive(1, 32'h0000_2000, 3'b001, 1);
        chk("full2_sready", 32'(s_ready), 32'd0);
        tick;
        drive(1, 32'h0000_2000, 3'b001, 1);
        chk("simul_sready", 32'(s_ready), 32'd1);
        tick;
        drive(1, 32'h0000_2000, 3'b001, 0);
        chk("after_simul_sready", 32'(s_ready), 32'd1);
        tick;
        drive(1, 32'h0000_2000, 3'b001, 0);
        chk("full3_sready", 32'(s_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0000_2000, 3'b001, 1);
            tick;
            chk("drain_busy", 32'(busy), (i == 3) ? 32'd0 : 32'd1);
        end
        drive(0, 32'hFFFF_0000, 3'b100, 1);
        tick;
        chk("uf_set", 32'(underflow_err), 32'd1);
        chk("uf_busy", 32'(busy), 32'd0);
        drive(1, 32'hFFFF_0000, 3'b100, 0);
        chk("dflt_mvalid", 32'(m_valid), 32'b100);
        chk("dflt_sready", 32'(s_ready), 32'd1);
        tick;
        chk("dflt_cursel", 32'(cur_sel), 32'd2);
        chk("dflt_busy", 32'(busy), 32'd1);
        chk("uf_hold", 32'(underflow_err), 32'd1);
        drive(0, 32'hFFFF_0000, 3'b100, 1);
        tick;
        chk("dflt_done_busy", 32'(busy), 32'd0);
        chk("uf_hold2", 32'(underflow_err), 32'd1);
        rst = 1'b1;
        drive(0, 32'h0, 3'b000, 0);
        tick;
        chk("uf_clear", 32'(underflow_err), 32'd0);
        chk("rst_cursel", 32'(cur_sel), 32'd2);
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
